alu_result_stage: RTL and testbench

//   Registered output stage directly downstream of the 4-bit ALU (add/sub/compare/and).

---
 rtl/alu_result_stage.sv | 150 +++++++++++++++
 tb/tb_alu_result_stage.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered result/flag capture behind the 4-bit ALU,
// buffered in a small FIFO and handed out over valid/ready.
module alu_result_stage #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [1:0]                   op,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic [WIDTH-1:0]             sum,
    input  logic                         carry,
    input  logic [2:0]                   cmp,
    input  logic [WIDTH-1:0]             and_res,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [1:0]                   out_op,
    output logic [WIDTH-1:0]             out_result,
    output logic [3:0]                   out_flags,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf_sticky,
    input  logic                         ovf_clr
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_CMP = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;   // {V,N,C,Z}
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           in_entry;
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             push;
    logic             pop;
    logic             v_flag;
    logic             n_flag;
    logic             c_flag;
    logic             z_flag;
    logic [WIDTH-1:0] result;

    // Result select and flag derivation for the entry presented this cycle
    always_comb begin
        result = sum;
        v_flag = 1'b0;
        n_flag = 1'b0;
        c_flag = 1'b0;
        unique case (op)
            OP_ADD: begin
                result = sum;
                c_flag = carry;
                n_flag = sum[MSB];
                v_flag = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                result = sum;
                c_flag = carry;
                n_flag = sum[MSB];
                v_flag = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_CMP: begin
                result = WIDTH'(cmp);
            end
            OP_AND: begin
                result = and_res;
                n_flag = and_res[MSB];
            end
            default: begin
                result = sum;
            end
        endcase
        z_flag          = (result == '0);
        in_entry.op     = op;
        in_entry.result = result;
        in_entry.flags  = {v_flag, n_flag, c_flag, z_flag};
    end

    // Handshake decode; ready depends only on reset and stored level
    always_comb begin
        in_ready  = rst_n && (count < LVL_W'(DEPTH));
        out_valid = (count != '0);
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Entry storage; contents are masked at the output so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_entry;
        end
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
            // a V=1 push on the same edge as a clear keeps the indicator set
            if (push && in_entry.flags[3]) begin
                ovf_sticky <= 1'b1;
            end else if (ovf_clr) begin
                ovf_sticky <= 1'b0;
            end
        end
    end

    // Head entry presentation, zeroed whenever nothing is held
    always_comb begin
        head       = mem[rd_ptr];
        out_op     = 2'b00;
        out_result = '0;
        out_flags  = 4'b0000;
        if (out_valid) begin
            out_op     = head.op;
            out_result = head.result;
            out_flags  = head.flags;
        end
        level = count;
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: directed vectors with hand-computed expectations.
module tb_alu_result_stage;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] sum;
    logic       carry;
    logic [2:0] cmp;
    logic [3:0] and_res;
    logic       out_valid;
    logic       out_ready;
    logic [1:0] out_op;
    logic [3:0] out_result;
    logic [3:0] out_flags;
    logic [1:0] level;
    logic       ovf_sticky;
    logic       ovf_clr;

    int checks;
    int errors;

    alu_result_stage #(.WIDTH(4), .DEPTH(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .sum        (sum),
        .carry      (carry),
        .cmp        (cmp),
        .and_res    (and_res),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_result (out_result),
        .out_flags  (out_flags),
        .level      (level),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] o, input logic [3:0] va, input logic [3:0] vb,
                         input logic [3:0] vs, input logic vc, input logic [2:0] vcmp,
                         input logic [3:0] vand);
        in_valid = 1'b1;
        op       = o;
        a        = va;
        b        = vb;
        sum      = vs;
        carry    = vc;
        cmp      = vcmp;
        and_res  = vand;
    endtask

    task automatic head_is(input string tag, input logic [1:0] eop,
                           input logic [3:0] eres, input logic [3:0] eflg);
        check({tag, "_valid"},  16'(out_valid),  16'(1));
        check({tag, "_op"},     16'(out_op),     16'(eop));
        check({tag, "_result"}, 16'(out_result), 16'(eres));
        check({tag, "_flags"},  16'(out_flags),  16'(eflg));
    endtask

    task automatic pop_one();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        op = 2'b00; a = '0; b = '0; sum = '0; carry = 1'b0; cmp = '0; and_res = '0;

        // Reset state
        #12;
        check("rst_in_ready",  16'(in_ready),   16'(0));
        check("rst_out_valid", 16'(out_valid),  16'(0));
        check("rst_level",     16'(level),      16'(0));
        check("rst_result",    16'(out_result), 16'(0));
        check("rst_sticky",    16'(ovf_sticky), 16'(0));
        #4 rst_n = 1'b1;
        step();
        check("rel_in_ready",  16'(in_ready),   16'(1));

        // 1: add with signed overflow
        drive(2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 3'b000, 4'b0000);
        step();
        in_valid = 1'b0;
        head_is("add_ovf", 2'b00, 4'b1000, 4'b1100);
        check("add_ovf_sticky", 16'(ovf_sticky), 16'(1));
        check("add_ovf_level",  16'(level),      16'(1));
        pop_one();
        check("pop_empty_valid",  16'(out_valid),  16'(0));
        check("pop_empty_result", 16'(out_result), 16'(0));
        check("pop_empty_flags",  16'(out_flags),  16'(0));
        check("pop_empty_op",     16'(out_op),     16'(0));

        // 2: sub to zero, then clear sticky
        drive(2'b01, 4'b0011, 4'b0011, 4'b0000, 1'b1, 3'b000, 4'b0000);
        step();
        in_valid = 1'b0;
        head_is("sub_zero", 2'b01, 4'b0000, 4'b0011);
        check("sub_sticky_held", 16'(ovf_sticky), 16'(1));
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_sticky", 16'(ovf_sticky), 16'(0));
        pop_one();

        // Sub overflow: 0111 - 1111 = 1000, set beats simultaneous clear
        drive(2'b01, 4'b0111, 4'b1111, 4'b1000, 1'b0, 3'b000, 4'b0000);
        ovf_clr = 1'b1;
        step();
        in_valid = 1'b0;
        ovf_clr  = 1'b0;
        head_is("sub_ovf", 2'b01, 4'b1000, 4'b1100);
        check("set_beats_clr", 16'(ovf_sticky), 16'(1));
        pop_one();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("clr_again", 16'(ovf_sticky), 16'(0));

        // 3: compare ignores sum/carry; and drives N and Z
        drive(2'b10, 4'b0111, 4'b0001, 4'b1111, 1'b1, 3'b100, 4'b1111);
        step();
        in_valid = 1'b0;
        head_is("cmp", 2'b10, 4'b0100, 4'b0000);
        pop_one();
        drive(2'b11, 4'b1110, 4'b1011, 4'b1111, 1'b1, 3'b010, 4'b1010);
        step();
        in_valid = 1'b0;
        head_is("and_neg", 2'b11, 4'b1010, 4'b0100);
        pop_one();
        drive(2'b11, 4'b1100, 4'b0011, 4'b0001, 1'b1, 3'b001, 4'b0000);
        step();
        in_valid = 1'b0;
        head_is("and_zero", 2'b11, 4'b0000, 4'b0001);
        check("no_ovf_from_and", 16'(ovf_sticky), 16'(0));
        pop_one();

        // 4/5: back-to-back pushes with consumer stalled, then drain in order
        drive(2'b00, 4'b0001, 4'b0001, 4'b0010, 1'b0, 3'b000, 4'b0000);
        step();
        check("fill1_level", 16'(level),    16'(1));
        check("fill1_ready", 16'(in_ready), 16'(1));
        drive(2'b11, 4'b0111, 4'b0011, 4'b1010, 1'b0, 3'b000, 4'b0011);
        step();
        check("fill2_level", 16'(level),    16'(2));
        check("fill2_ready", 16'(in_ready), 16'(0));
        drive(2'b10, 4'b0001, 4'b0010, 4'b1111, 1'b0, 3'b001, 4'b0000);
        step();
        check("held_level", 16'(level), 16'(2));
        head_is("held_head", 2'b00, 4'b0010, 4'b0000);
        out_ready = 1'b1;
        step();
        check("full_pop_level", 16'(level),    16'(1));
        check("full_pop_ready", 16'(in_ready), 16'(1));
        head_is("order2", 2'b11, 4'b0011, 4'b0000);
        step();
        in_valid = 1'b0;
        check("pushpop_level", 16'(level), 16'(1));
        head_is("order3", 2'b10, 4'b0001, 4'b0000);
        step();
        out_ready = 1'b0;
        check("drain_level", 16'(level),     16'(0));
        check("drain_valid", 16'(out_valid), 16'(0));

        // 6: asynchronous reset with full FIFO and sticky set
        drive(2'b00, 4'b0111, 4'b0001, 4'b1000, 1'b0, 3'b000, 4'b0000);
        step();
        step();
        in_valid = 1'b0;
        check("pre_rst_level",  16'(level),      16'(2));
        check("pre_rst_sticky", 16'(ovf_sticky), 16'(1));
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid",  16'(out_valid),  16'(0));
        check("arst_level",  16'(level),      16'(0));
        check("arst_sticky", 16'(ovf_sticky), 16'(0));
        check("arst_ready",  16'(in_ready),   16'(0));
        check("arst_result", 16'(out_result), 16'(0));
        check("arst_flags",  16'(out_flags),  16'(0));
        step();
        check("arst_hold_level", 16'(level), 16'(0));
        #2 rst_n = 1'b1;
        step();
        check("post_rst_ready", 16'(in_ready), 16'(1));
        drive(2'b01, 4'b0101, 4'b0011, 4'b0010, 1'b1, 3'b000, 4'b0000);
        step();
        in_valid = 1'b0;
        check("post_rst_level", 16'(level), 16'(1));
        head_is("post_rst", 2'b01, 4'b0010, 4'b0010);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
